mem_cmd_master: RTL and testbench

- Command-driven initiator for the single-port synchronous memory. It owns the other end of the addr/wr_en/rd_en/wr_data/rd_data interface.
- Accepts single and burst read/write commands over a valid/ready port and sequences them onto the memory port.
- Returns read data over a valid/ready response port with backpressure.
- Sits between test/stimulus logic or a bus bridge and the memory instance.

---
 rtl/mem_cmd_master.sv | 187 ++++++++++++++++++
 tb/tb_mem_cmd_master.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_cmd_master.sv
// Command-driven initiator for a single-port synchronous memory: sequences single and
// burst read/write commands onto the memory port and returns read data with backpressure.
module mem_cmd_master #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 3,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_last,
    output logic                  busy,
    output logic                  done
);

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t                state_r, state_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_s;
    logic [DATA_WIDTH-1:0] wdata_r, wdata_s;
    logic [LEN_WIDTH-1:0]  beat_r, beat_s;
    logic [LAT_W-1:0]      wait_r, wait_s;
    logic                  wr_en_r, wr_en_s;
    logic                  rd_en_r, rd_en_s;
    logic                  rsp_valid_r, rsp_valid_s;
    logic [DATA_WIDTH-1:0] rsp_data_r, rsp_data_s;
    logic                  rsp_last_r, rsp_last_s;
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;
    logic                  cmd_ready_r, cmd_ready_s;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_s     = state_r;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        beat_s      = beat_r;
        wait_s      = wait_r;
        wr_en_s     = 1'b0;
        rd_en_s     = 1'b0;
        rsp_valid_s = rsp_valid_r;
        rsp_data_s  = rsp_data_r;
        rsp_last_s  = rsp_last_r;
        done_s      = 1'b0;
        cmd_ready_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    addr_s = cmd_addr;
                    beat_s = cmd_op[1] ? cmd_len : {LEN_WIDTH{1'b0}};
                    if (cmd_op[0]) begin
                        state_s = RD_ISSUE;
                        rd_en_s = 1'b1;
                    end else begin
                        state_s = WRITE;
                        wdata_s = cmd_data;
                        wr_en_s = 1'b1;
                    end
                end else begin
                    cmd_ready_s = 1'b1;
                end
            end
            WRITE: begin
                if (beat_r == {LEN_WIDTH{1'b0}}) begin
                    state_s     = IDLE;
                    done_s      = 1'b1;
                    cmd_ready_s = 1'b1;
                end else begin
                    beat_s  = beat_r - LEN_WIDTH'(1);
                    addr_s  = addr_r + ADDR_WIDTH'(1);
                    wdata_s = wdata_r + DATA_WIDTH'(1);
                    wr_en_s = 1'b1;
                end
            end
            RD_ISSUE: begin
                state_s = RD_WAIT;
                wait_s  = LAT_W'(RD_LAT - 1);
            end
            RD_WAIT: begin
                if (wait_r == {LAT_W{1'b0}}) begin
                    state_s     = RESP;
                    rsp_data_s  = mem_rd_data;
                    rsp_valid_s = 1'b1;
                    rsp_last_s  = (beat_r == {LEN_WIDTH{1'b0}});
                end else begin
                    wait_s = wait_r - LAT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_s = 1'b0;
                    rsp_last_s  = 1'b0;
                    if (beat_r == {LEN_WIDTH{1'b0}}) begin
                        state_s     = IDLE;
                        done_s      = 1'b1;
                        cmd_ready_s = 1'b1;
                    end else begin
                        state_s = RD_ISSUE;
                        beat_s  = beat_r - LEN_WIDTH'(1);
                        addr_s  = addr_r + ADDR_WIDTH'(1);
                        rd_en_s = 1'b1;
                    end
                end else begin
                    rsp_valid_s = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // Datapath and output registers; reset drops strobes and any in-flight command.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r      <= {ADDR_WIDTH{1'b0}};
            wdata_r     <= {DATA_WIDTH{1'b0}};
            beat_r      <= {LEN_WIDTH{1'b0}};
            wait_r      <= {LAT_W{1'b0}};
            wr_en_r     <= 1'b0;
            rd_en_r     <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {DATA_WIDTH{1'b0}};
            rsp_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cmd_ready_r <= 1'b0;
        end else begin
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            beat_r      <= beat_s;
            wait_r      <= wait_s;
            wr_en_r     <= wr_en_s;
            rd_en_r     <= rd_en_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_data_r  <= rsp_data_s;
            rsp_last_r  <= rsp_last_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            cmd_ready_r <= cmd_ready_s;
        end
    end

    assign cmd_ready   = cmd_ready_r;
    assign mem_addr    = addr_r;
    assign mem_wr_en   = wr_en_r;
    assign mem_rd_en   = rd_en_r;
    assign mem_wr_data = wdata_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_data    = rsp_data_r;
    assign rsp_last    = rsp_last_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_mem_cmd_master.sv
// Randomized self-checking bench for mem_cmd_master against a command-level reference
// model (shadow memory plus expected write/response queues) and a behavioural memory.
module tb_mem_cmd_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_addr;
    logic [7:0] cmd_data;
    logic [2:0] cmd_len;
    logic [2:0] mem_addr;
    logic       mem_wr_en;
    logic       mem_rd_en;
    logic [7:0] mem_wr_data;
    logic [7:0] mem_rd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_last;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;
    int rdy_mode = 1;

    logic [7:0]  shadow [8];
    logic [10:0] exp_wr_q [$];
    logic [8:0]  exp_rsp_q [$];

    mem_cmd_master #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .LEN_WIDTH(3), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_len(cmd_len),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int i);
        return 8'(i * 37 + 5);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural single-port memory with one cycle read latency; contents survive reset.
    logic [7:0] dev_mem [8];
    bit         mem_loaded;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 8; i++) dev_mem[i] <= init_val(i);
            mem_loaded <= 1'b1;
        end else begin
            if (mem_wr_en) dev_mem[mem_addr] <= mem_wr_data;
            if (mem_rd_en) mem_rd_data <= dev_mem[mem_addr];
        end
    end

    // Response consumer: ready driven away from the active edge.
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       rsp_ready <= 1'b0;
            1:       rsp_ready <= 1'b1;
            default: rsp_ready <= 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: memory writes, response beats and response stability against the model.
    logic       prev_valid, prev_ready, prev_last;
    logic [7:0] prev_data;
    always @(negedge clk) begin
        logic [10:0] ew;
        logic [8:0]  er;
        if (!rst) begin
            prev_valid <= 1'b0;
        end else begin
            check_val("strobe_excl", {31'd0, mem_wr_en & mem_rd_en}, 32'd0);
            if (mem_wr_en) begin
                if (exp_wr_q.size() == 0) check_val("wr_unexpected", 32'd1, 32'd0);
                else begin
                    ew = exp_wr_q.pop_front();
                    check_val("wr_addr", {29'd0, mem_addr}, {29'd0, ew[10:8]});
                    check_val("wr_data", {24'd0, mem_wr_data}, {24'd0, ew[7:0]});
                end
            end
            if (prev_valid && !prev_ready) begin
                check_val("rsp_hold_valid", {31'd0, rsp_valid}, 32'd1);
                check_val("rsp_hold_data", {24'd0, rsp_data}, {24'd0, prev_data});
                check_val("rsp_hold_last", {31'd0, rsp_last}, {31'd0, prev_last});
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_rsp_q.size() == 0) check_val("rsp_unexpected", 32'd1, 32'd0);
                else begin
                    er = exp_rsp_q.pop_front();
                    check_val("rsp_data", {24'd0, rsp_data}, {24'd0, er[8:1]});
                    check_val("rsp_last", {31'd0, rsp_last}, {31'd0, er[0]});
                end
            end
            prev_valid <= rsp_valid;
            prev_ready <= rsp_ready;
            prev_data  <= rsp_data;
            prev_last  <= rsp_last;
        end
    end

    // Reference model: effect of a whole command on memory and on the response stream.
    task automatic model_cmd(input logic [1:0] op, input logic [2:0] a, input logic [7:0] d,
                             input logic [2:0] l);
        int beats = op[1] ? int'(l) + 1 : 1;
        logic [2:0] aa = a;
        logic [7:0] dd = d;
        for (int i = 0; i < beats; i++) begin
            if (!op[0]) begin
                exp_wr_q.push_back({aa, dd});
                shadow[aa] = dd;
                dd = dd + 8'd1;
            end else begin
                exp_rsp_q.push_back({shadow[aa], (i == beats - 1)});
            end
            aa = aa + 3'd1;
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [2:0] a, input logic [7:0] d,
                            input logic [2:0] l);
        int n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("cmd_ready_wait", {31'd0, n < 100}, 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; cmd_len = l;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int n, output int busy_n, output int rd_n, output bit seen);
        n = 0; busy_n = 0; rd_n = 0; seen = 1'b0;
        while (!seen && n < 300) begin
            @(negedge clk);
            n++;
            if (busy) busy_n++;
            if (mem_rd_en) rd_n++;
            if (done) seen = 1'b1;
        end
        check_val("done_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [2:0] a, input logic [7:0] d,
                           input logic [2:0] l);
        int n, busy_n, rd_n;
        bit seen;
        int leff = op[1] ? int'(l) : 0;
        model_cmd(op, a, d, l);
        send_cmd(op, a, d, l);
        wait_done(n, busy_n, rd_n, seen);
        if (!op[0]) begin
            check_val("wr_done_latency", n, leff + 2);
            check_val("wr_busy_cycles", busy_n, leff + 1);
        end else begin
            check_val("rd_pulses", rd_n, leff + 1);
        end
        check_val("ready_at_done", {31'd0, cmd_ready}, 32'd1);
        check_val("busy_at_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check_val("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, busy_n, rd_n;
        bit seen, acc;
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 3'd0; cmd_data = 8'd0;
        cmd_len = 3'd0;
        for (int i = 0; i < 8; i++) shadow[i] = init_val(i);
        repeat (3) @(negedge clk);
        check_val("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check_val("rst_strobes", {30'd0, mem_wr_en, mem_rd_en}, 32'd0);
        check_val("rst_rsp", {22'd0, rsp_valid, rsp_last, rsp_data}, 32'd0);
        check_val("rst_busy_done", {30'd0, busy, done}, 32'd0);
        check_val("rst_mem_bus", {21'd0, mem_addr, mem_wr_data}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_val("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

        // Single write, wrapping fill burst, read back of the burst.
        run_cmd(2'b00, 3'd3, 8'hA5, 3'd0);
        run_cmd(2'b10, 3'd6, 8'hFE, 3'd3);
        run_cmd(2'b11, 3'd6, 8'h00, 3'd3);

        // Single read held under backpressure.
        rdy_mode = 0;
        model_cmd(2'b01, 3'd3, 8'h00, 3'd0);
        send_cmd(2'b01, 3'd3, 8'h00, 3'd0);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check_val("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check_val("bp_data", {24'd0, rsp_data}, 32'h0000_00A5);
            check_val("bp_no_rd", {31'd0, mem_rd_en}, 32'd0);
            check_val("bp_not_ready", {31'd0, cmd_ready}, 32'd0);
            @(negedge clk);
        end
        rdy_mode = 1;
        wait_done(n, busy_n, rd_n, seen);
        check_val("bp_rd_pulses", rd_n, 0);

        // Command held valid during a burst is taken only in the done cycle.
        model_cmd(2'b10, 3'd2, 8'h30, 3'd3);
        send_cmd(2'b10, 3'd2, 8'h30, 3'd3);
        model_cmd(2'b11, 3'd2, 8'h00, 3'd3);
        cmd_valid = 1'b1; cmd_op = 2'b11; cmd_addr = 3'd2; cmd_data = 8'h00; cmd_len = 3'd3;
        n = 0; acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            n++;
            if (cmd_ready) begin
                check_val("held_ready_with_done", {31'd0, done}, 32'd1);
                acc = 1'b1;
            end
        end
        check_val("held_accept_cycle", n, 5);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_done(n, busy_n, rd_n, seen);
        check_val("held_rd_pulses", rd_n, 4);

        // Reset during the second beat of a long fill burst.
        exp_wr_q.push_back({3'd0, 8'h40});
        exp_wr_q.push_back({3'd1, 8'h41});
        shadow[0] = 8'h40;
        send_cmd(2'b10, 3'd0, 8'h40, 3'd7);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_val("mid_rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_val("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
        check_val("mid_rst_wr_queue", exp_wr_q.size(), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("rerst_ready", {31'd0, cmd_ready}, 32'd1);
        check_val("rerst_busy", {31'd0, busy}, 32'd0);
        run_cmd(2'b11, 3'd0, 8'h00, 3'd7);

        // Randomized command mix with random backpressure.
        rdy_mode = 2;
        for (int k = 0; k < 40; k++) begin
            run_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                    8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
        end
        rdy_mode = 1;
        run_cmd(2'b11, 3'd0, 8'h00, 3'd7);

        check_val("wr_queue_empty", exp_wr_q.size(), 0);
        check_val("rsp_queue_empty", exp_rsp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
